// File: rtl/flag_status_reg.sv
// flag_status_reg: processor status register behind the ALU.
// Holds the N/Z/F/L/C flags (bit order [4]=N [3]=Z [2]=F [1]=L [0]=C),
// evaluates branch condition codes against them, and keeps a one-deep
// shadow copy for interrupt entry/return.
module flag_status_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       aluC,
  input  logic       aluL,
  input  logic       aluF,
  input  logic       aluZ,
  input  logic       aluN,
  input  logic       flagWrite,
  input  logic [4:0] flagMask,
  input  logic       psrLoad,
  input  logic [4:0] psrIn,
  input  logic       save,
  input  logic       restore,
  input  logic [3:0] cond,
  output logic       C,
  output logic       L,
  output logic       F,
  output logic       Z,
  output logic       N,
  output logic [4:0] psrOut,
  output logic       condTrue,
  output logic       savedValid,
  output logic       saveOverflow
);

  logic [4:0] flags_q, flags_d;
  logic [4:0] shadow_q, shadow_d;
  logic       saved_valid_q, saved_valid_d;
  logic       save_overflow_q, save_overflow_d;
  logic [4:0] alu_flags;
  logic       do_restore;

  assign alu_flags  = {aluN, aluZ, aluF, aluL, aluC};
  // A restore only counts when the shadow actually holds something; an
  // empty restore must not shadow the lower-priority flag updates.
  assign do_restore = restore & saved_valid_q;

  // Next-state: restore > psrLoad > masked flagWrite; save/overflow tracking.
  always_comb begin
    flags_d         = flags_q;
    shadow_d        = shadow_q;
    saved_valid_d   = saved_valid_q;
    save_overflow_d = save_overflow_q;

    if (do_restore) begin
      flags_d       = shadow_q;
      saved_valid_d = 1'b0;
    end else if (psrLoad) begin
      flags_d = psrIn;
    end else if (flagWrite) begin
      flags_d = (flags_q & ~flagMask) | (alu_flags & flagMask);
    end

    // Save captures the pre-update flags; any restore request in the same
    // cycle suppresses the save entirely (no shadow write, no overflow).
    if (save && !restore) begin
      if (saved_valid_q) begin
        save_overflow_d = 1'b1;
      end else begin
        shadow_d      = flags_q;
        saved_valid_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q         <= 5'b00000;
      shadow_q        <= 5'b00000;
      saved_valid_q   <= 1'b0;
      save_overflow_q <= 1'b0;
    end else begin
      flags_q         <= flags_d;
      shadow_q        <= shadow_d;
      saved_valid_q   <= saved_valid_d;
      save_overflow_q <= save_overflow_d;
    end
  end

  // Condition evaluation against the registered flags only (no forwarding).
  always_comb begin
    condTrue = 1'b0;
    case (cond)
      4'b0000: condTrue = flags_q[3];
      4'b0001: condTrue = ~flags_q[3];
      4'b0010: condTrue = flags_q[0];
      4'b0011: condTrue = ~flags_q[0];
      4'b0100: condTrue = ~flags_q[1] & ~flags_q[3];
      4'b0101: condTrue = flags_q[1] | flags_q[3];
      4'b0110: condTrue = ~flags_q[4] & ~flags_q[3];
      4'b0111: condTrue = flags_q[4] | flags_q[3];
      4'b1000: condTrue = flags_q[2];
      4'b1001: condTrue = ~flags_q[2];
      4'b1010: condTrue = flags_q[1];
      4'b1011: condTrue = ~flags_q[1];
      4'b1100: condTrue = flags_q[4];
      4'b1101: condTrue = ~flags_q[4];
      4'b1110: condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  end

  assign N            = flags_q[4];
  assign Z            = flags_q[3];
  assign F            = flags_q[2];
  assign L            = flags_q[1];
  assign C            = flags_q[0];
  assign psrOut       = flags_q;
  assign savedValid   = saved_valid_q;
  assign saveOverflow = save_overflow_q;

endmodule

// File: tb/tb_flag_status_reg.sv
// Directed testbench for flag_status_reg with immediate-assertion checks.
module tb_flag_status_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       aluC, aluL, aluF, aluZ, aluN;
  logic       flagWrite;
  logic [4:0] flagMask;
  logic       psrLoad;
  logic [4:0] psrIn;
  logic       save, restore;
  logic [3:0] cond;
  logic       C, L, F, Z, N;
  logic [4:0] psrOut;
  logic       condTrue, savedValid, saveOverflow;

  int n_checks = 0;
  int n_fail   = 0;

  flag_status_reg dut (
    .clk(clk), .reset(reset),
    .aluC(aluC), .aluL(aluL), .aluF(aluF), .aluZ(aluZ), .aluN(aluN),
    .flagWrite(flagWrite), .flagMask(flagMask),
    .psrLoad(psrLoad), .psrIn(psrIn),
    .save(save), .restore(restore), .cond(cond),
    .C(C), .L(L), .F(F), .Z(Z), .N(N),
    .psrOut(psrOut), .condTrue(condTrue),
    .savedValid(savedValid), .saveOverflow(saveOverflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic [4:0] v);
    {aluN, aluZ, aluF, aluL, aluC} = v;
  endtask

  // One clock edge, sample #1 after it, then return request pulses to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    reset = 1'b0; flagWrite = 1'b0; psrLoad = 1'b0; save = 1'b0; restore = 1'b0;
  endtask

  // Sweep all 16 condition codes against a table (bit i = expected for cond i).
  task automatic sweep(input string tag, input logic [15:0] table_bits);
    for (int i = 0; i < 16; i++) begin
      cond = i[3:0];
      #1;
      check($sformatf("%s_cond%0d", tag, i), {4'b0, condTrue}, {4'b0, table_bits[i]});
    end
  endtask

  initial begin
    reset = 1'b1; flagWrite = 1'b0; flagMask = 5'b0; psrLoad = 1'b0; psrIn = 5'b0;
    save = 1'b0; restore = 1'b0; cond = 4'b0001; set_alu(5'b0);

    // Reset state.
    tick();
    $display("step reset");
    cond = 4'b0001; #1;
    check("rst_ne", {4'b0, condTrue}, 5'd1);
    check("rst_psr", psrOut, 5'b00000);
    check("rst_valid", {4'b0, savedValid}, 5'd0);
    check("rst_ovf", {4'b0, saveOverflow}, 5'd0);
    sweep("zero", 16'h6A5A);

    // Preload F and C, then CMP 2 vs 3 with mask N,Z,L: F/C must hold.
    psrLoad = 1'b1; psrIn = 5'b00101; tick();
    $display("step load 00101");
    check("pre_psr", psrOut, 5'b00101);
    set_alu(5'b10010); flagWrite = 1'b1; flagMask = 5'b11010; tick();
    $display("step cmp mask 11010");
    check("cmp_psr", psrOut, 5'b10111);
    check("cmp_bits", {N, Z, F, L, C}, 5'b10111);
    cond = 4'b1010; #1; check("cmp_lo", {4'b0, condTrue}, 5'd1);
    cond = 4'b0100; #1; check("cmp_hi", {4'b0, condTrue}, 5'd0);
    sweep("cmp", 16'h55A6);

    // psrLoad beats flagWrite in the same cycle.
    set_alu(5'b00000); flagWrite = 1'b1; flagMask = 5'b11111;
    psrLoad = 1'b1; psrIn = 5'b01101; tick();
    $display("step load+write");
    check("load_wins", psrOut, 5'b01101);
    cond = 4'b1000; #1; check("load_fs", {4'b0, condTrue}, 5'd1);
    cond = 4'b0000; #1; check("load_eq", {4'b0, condTrue}, 5'd1);

    // Empty mask changes nothing.
    set_alu(5'b11111); flagWrite = 1'b1; flagMask = 5'b00000; tick();
    $display("step write mask 0");
    check("mask0", psrOut, 5'b01101);

    // Save, overwrite, restore.
    psrLoad = 1'b1; psrIn = 5'b00001; tick();
    save = 1'b1; tick();
    $display("step save");
    check("save_valid", {4'b0, savedValid}, 5'd1);
    check("save_psr", psrOut, 5'b00001);
    set_alu(5'b11110); flagWrite = 1'b1; flagMask = 5'b11111; tick();
    $display("step write 11110");
    check("ovw_psr", psrOut, 5'b11110);
    restore = 1'b1; tick();
    $display("step restore");
    check("rest_psr", psrOut, 5'b00001);
    check("rest_valid", {4'b0, savedValid}, 5'd0);

    // Double save: overflow, shadow keeps first value; live load still applies.
    save = 1'b1; tick();
    save = 1'b1; psrLoad = 1'b1; psrIn = 5'b01010; tick();
    $display("step second save");
    check("ovf_set", {4'b0, saveOverflow}, 5'd1);
    check("ovf_live", psrOut, 5'b01010);
    check("ovf_valid", {4'b0, savedValid}, 5'd1);
    save = 1'b1; restore = 1'b1; tick();
    $display("step save+restore");
    check("sr_psr", psrOut, 5'b00001);
    check("sr_valid", {4'b0, savedValid}, 5'd0);
    check("sr_ovf", {4'b0, saveOverflow}, 5'd1);

    // Restore with empty shadow does not block psrLoad.
    restore = 1'b1; psrLoad = 1'b1; psrIn = 5'b00110; tick();
    $display("step empty restore+load");
    check("erest_psr", psrOut, 5'b00110);
    check("erest_valid", {4'b0, savedValid}, 5'd0);

    // Reset discards a valid shadow.
    save = 1'b1; tick();
    check("pre_rst_valid", {4'b0, savedValid}, 5'd1);
    reset = 1'b1; tick();
    $display("step mid reset");
    check("mrst_valid", {4'b0, savedValid}, 5'd0);
    check("mrst_ovf", {4'b0, saveOverflow}, 5'd0);
    restore = 1'b1; tick();
    $display("step restore after reset");
    check("mrst_psr", psrOut, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_status_reg.md
# flag_status_reg

Processor status register stage directly downstream of the `alu`. It captures the ALU's five combinational flags (C, L, F, Z, N) under a per-flag write mask and holds them between instructions. It evaluates a 4-bit branch/jump condition code against the held flags. It also provides a single-level shadow copy for interrupt entry and return, plus an explicit load path for the move-to-PSR instruction.

## Interface
- No parameters. Flag vector width is fixed at 5. Bit order everywhere: [4]=N, [3]=Z, [2]=F, [1]=L, [0]=C.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `aluC`, `aluL`, `aluF`, `aluZ`, `aluN` in 1 each: flags straight from the `alu` outputs.
- `flagWrite` in 1: capture ALU flags this cycle, qualified by `flagMask`.
- `flagMask` in 5: per-flag enable for `flagWrite`. Example: ADD uses 5'b00101 (F, C); CMP uses 5'b11010 (N, Z, L).
- `psrLoad` in 1: load all five flags from `psrIn`.
- `psrIn` in 5: explicit PSR value.
- `save` in 1: copy current flags into the shadow register (interrupt entry).
- `restore` in 1: copy shadow into flags (interrupt return).
- `cond` in 4: condition code to evaluate.
- `C`, `L`, `F`, `Z`, `N` out 1 each: registered flags.
- `psrOut` out 5: registered flags as a vector.
- `condTrue` out 1: combinational result of `cond` against the registered flags.
- `savedValid` out 1: shadow holds a valid copy.
- `saveOverflow` out 1: sticky error flag; set when a save is attempted while `savedValid`=1.

## Operation
- Flag meanings are the ALU's:
  - C: unsigned carry/borrow.
  - L: unsigned a<b.
  - F: signed overflow.
  - Z: result or compare equal.
  - N: signed a<b.
- Flag register update priority per cycle, highest first: `reset` > `restore` (only if `savedValid`) > `psrLoad` > `flagWrite`.
  - Lower-priority requests in the same cycle are dropped, not deferred.
- `flagWrite` updates only the bits with `flagMask`=1; unmasked bits hold. `flagMask`=0 with `flagWrite`=1 changes nothing.
- `restore` with `savedValid`=0: no effect, and it does not block `psrLoad`/`flagWrite` in that cycle.
- `restore` with `savedValid`=1: flags <= shadow, `savedValid` <= 0.
- `save` with `savedValid`=0 and no `restore`: shadow <= current (pre-update) flags, `savedValid` <= 1. Any flag update in the same cycle still applies to the live flags.
- `save` with `savedValid`=1: shadow unchanged, `saveOverflow` <= 1. It stays 1 until reset.
- `save` and `restore` in the same cycle: `restore` acts, `save` is ignored, and `saveOverflow` is not set.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: !L&!Z
  - 0101 LS: L|Z
  - 0110 GT: !N&!Z
  - 0111 LE: N|Z
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: L
  - 1011 HS: !L
  - 1100 LT: N
  - 1101 GE: !N
  - 1110 UC: 1
  - 1111 NV: 0
- No forwarding: `condTrue` always reflects the registered flags, never the current ALU inputs.

## Timing
- Reset (synchronous): flags=0, `psrOut`=0, shadow=0, `savedValid`=0, `saveOverflow`=0.
  - `condTrue` after reset follows the table with all flags 0 (e.g. NE=1, EQ=0, UC=1).
- Reset mid-sequence (for example, while shadow is valid) discards the shadow and clears `savedValid`.
- Latency:
  - Flags written at edge k are visible on the outputs and in `condTrue` after edge k. A dependent branch uses them in cycle k+1.
  - `condTrue` has zero-cycle combinational latency from `cond`.
- All inputs are sampled only at the rising edge. No handshakes; every request is a single-cycle pulse, and a level held high acts every cycle.

## Test plan
- Reset, then `cond`=0001 -> `condTrue`=1, `psrOut`=5'b00000, `savedValid`=0.
- ALU CMP a=2, b=3 (L=1, N=1, Z=0) with `flagWrite`=1, mask 5'b11010 -> next cycle L=1, N=1, Z=0, C/F unchanged. `cond`=1010 -> 1; `cond`=0100 -> 0.
- `psrIn`=5'b01101 with `psrLoad`=1 and `flagWrite`=1 (ALU flags all 0, mask 5'b11111) in the same cycle -> `psrOut`=5'b01101 (load wins). `cond`=1000 -> 1.
- Flags 5'b00001, pulse `save`; next cycle `flagWrite` all-ones mask with ALU flags 5'b11110; then `restore` -> `psrOut` returns to 5'b00001, `savedValid`=0.
- `save` twice with no restore -> second attempt sets `saveOverflow`=1 and the shadow keeps the first value. `save`+`restore` together -> flags <= shadow, `savedValid`=0, `saveOverflow` unchanged.
- Shadow valid, then `reset` -> `savedValid`=0. A following `restore` leaves flags at 0.
